uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 10; the system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 1; the line bit rate in bits per second.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1 bit; the reset, synchronous and active-high.
REQ-005 SHALL have port rx, input, 1 bit; the asynchronous serial line, which idles high.
REQ-006 SHALL have port data, output, 8 bits; the received byte, held stable while valid=1.
REQ-007 SHALL have port valid, output, 1 bit; high when a received byte is waiting to be consumed.
REQ-008 SHALL have port ready, input, 1 bit; the consumer accepts data when valid and ready are both high.
REQ-009 SHALL have port frame_err, output, 1 bit; a one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port overrun, output, 1 bit; a one-cycle pulse when a good byte completes while valid=1 and ready=0.

Function
REQ-011 SHALL compute CLKS_PER_BAUD = CLOCK_HZ/BAUD_RATE using integer division; elaboration SHALL fail if CLKS_PER_BAUD < 4.
REQ-012 SHALL size the timer counter at $clog2(CLKS_PER_BAUD)+1 bits, with no 32-bit constant arithmetic in the datapath.
REQ-013 SHALL pass rx through a 2-flop synchronizer, giving rx_s; rx_s SHALL reset to 1.
REQ-014 SHALL implement FSM states IDLE, START, DATA and STOP.
REQ-015 IDLE: on a falling edge of rx_s (previous 1, current 0), the FSM SHALL move to START and load the timer for a half period (CLKS_PER_BAUD/2 clocks).
REQ-016 START: at the timer tick, if rx_s=0 the FSM SHALL move to DATA and reload the timer for a full period; if rx_s=1 (glitch) it SHALL return to IDLE with no outputs changed.
REQ-017 DATA: at each full-period tick, rx_s SHALL be shifted into the MSB of the shift register (LSB-first line order); after the 8th sample the FSM SHALL move to STOP.
REQ-018 STOP: at the next tick, if rx_s=1 the byte SHALL be delivered per REQ-019 and REQ-020; if rx_s=0, frame_err SHALL pulse, the byte SHALL be discarded, and valid/data SHALL be unchanged; the FSM SHALL go to IDLE in both cases.
REQ-019 Delivery with valid=0, or with valid=1 and ready=1 in the same cycle: data SHALL load the new byte and valid SHALL be 1 on the following cycle.
REQ-020 Delivery with valid=1 and ready=0: overrun SHALL pulse, the new byte SHALL be dropped, and the old byte SHALL remain.
REQ-021 valid SHALL clear on the cycle after valid&&ready when no delivery occurs in that cycle.
REQ-022 IDLE after STOP SHALL require a fresh falling edge, so a held-low break line produces exactly one frame_err and no further frames.
REQ-023 The timer SHALL tick only in START, DATA and STOP, and SHALL be held at 0 in IDLE.

Reset
REQ-024 Reset SHALL force: FSM=IDLE, timer=0, shift register=0, data=8'h00, valid=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no pulse on any output; reception SHALL resume only on a new falling edge after reset deasserts.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enum (uart_rx_state_t) and the constant UART_DATA_BITS=8.
REQ-027 The timer SHALL be a sub-module uart_rx_timer with inputs clk, reset, load_half, load_full, run and output tick, parameterised by CLKS_PER_BAUD.
REQ-028 The synchronizer, edge detector, FSM, shift register and output buffer SHALL reside in uart_rx.

Verification (CLOCK_HZ=16, BAUD_RATE=1, so 16 clocks per bit)
REQ-029 Frame 0x55 with stop=1 and ready=1 -> valid high for exactly one cycle with data=0x55; valid SHALL rise about 154 clocks (9.5 bits plus synchronizer delay) after the rx falling edge.
REQ-030 rx low for 4 clocks, then high -> FSM returns to IDLE and valid, frame_err and overrun all stay 0.
REQ-031 Frame 0xA3 with stop=0 -> frame_err pulses once, valid stays 0, data is unchanged; rx then held low for 200 clocks -> no further pulses.
REQ-032 Frames 0x12 then 0x34 back-to-back with ready=0 -> data=0x12 and valid=1, overrun pulses once at the end of 0x34; raising ready then clears valid on the next cycle.
REQ-033 Reset pulsed at the 5th data bit of frame 0xFF -> all outputs at reset values; the following frame 0x81 is received correctly.
REQ-034 Stop-bit delivery coinciding with valid&&ready on the previous byte -> no overrun, and valid stays 1 with the new byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_rx_timer.sv
// Bit-period down-counter for the UART receiver.
// load_half / load_full preload half or full bit periods; tick fires on the
// last clock of the loaded interval while run is high. Held at zero when idle.
module uart_rx_timer #(
    parameter int CLKS_PER_BAUD = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load_half,
    input  logic load_full,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BAUD) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BAUD);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BAUD / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: loads win, otherwise count down while running, else park at zero.
    always_comb begin
        count_d = count_q;
        if (load_half) begin
            count_d = HALF_CNT;
        end else if (load_full) begin
            count_d = FULL_CNT;
        end else if (run && (count_q != CNT_ZERO)) begin
            count_d = count_q - CNT_ONE;
        end else if (run) begin
            count_d = count_q;
        end else begin
            count_d = CNT_ZERO;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = run && (count_q == CNT_ONE);

endmodule : uart_rx_timer

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, with a one-entry valid/ready output buffer,
// frame-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ  = 10,
    parameter int BAUD_RATE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CLKS_PER_BAUD = CLOCK_HZ / BAUD_RATE;
    localparam int BIT_CNT_W     = $clog2(UART_DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(UART_DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_ONE  = {{(BIT_CNT_W-1){1'b0}}, 1'b1};

    generate
        if (CLKS_PER_BAUD < 4) begin : g_rate_check
            $error("uart_rx: CLOCK_HZ/BAUD_RATE must be at least 4");
        end
    endgenerate

    uart_rx_state_t state_q, state_d;

    logic                      rx_meta_q, rx_s_q, rx_prev_q;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      load_half_s, load_full_s, run_s, tick_s;
    logic                      fall_s;

    uart_rx_timer #(
        .CLKS_PER_BAUD(CLKS_PER_BAUD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_half(load_half_s),
        .load_full(load_full_s),
        .run      (run_s),
        .tick     (tick_s)
    );

    assign fall_s = rx_prev_q & ~rx_s_q;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection; idle-high on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // FSM next state, shift register, output buffer and pulse generation.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        load_half_s = 1'b0;
        load_full_s = 1'b0;
        run_s       = 1'b0;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            IDLE: begin
                if (fall_s) begin
                    state_d     = START;
                    load_half_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                run_s = 1'b1;
                if (tick_s) begin
                    if (!rx_s_q) begin
                        state_d     = DATA;
                        load_full_s = 1'b1;
                        bit_cnt_d   = {BIT_CNT_W{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                run_s = 1'b1;
                if (tick_s) begin
                    shift_d     = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
                    load_full_s = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = STOP;
                        bit_cnt_d = {BIT_CNT_W{1'b0}};
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                run_s = 1'b1;
                if (tick_s) begin
                    state_d = IDLE;
                    if (rx_s_q) begin
                        if (!valid_q || ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered FSM, datapath and outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= {UART_DATA_BITS{1'b0}};
            bit_cnt_q   <= {BIT_CNT_W{1'b0}};
            data_q      <= {UART_DATA_BITS{1'b0}};
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: a table of frames,
// hand-written corner sequences and random frames against a transaction-level model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed events (monitor)
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] obs_q[$];

    // Reference model state
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    int         m_fe    = 0;
    int         m_ov    = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_data;
        int         e_fe;
        int         e_ov;
    } vec_t;

    vec_t vecs[8];

    uart_rx #(
        .CLOCK_HZ (16),
        .BAUD_RATE(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Monitor: count pulses and record every accepted byte, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) fe_cnt <= fe_cnt + 1;
            if (overrun)   ov_cnt <= ov_cnt + 1;
            if (valid && ready) obs_q.push_back(data);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm);
        int n;
        chk({nm, "_valid"}, {31'd0, valid}, {31'd0, m_valid});
        chk({nm, "_data"}, {24'd0, data}, {24'd0, m_data});
        chk({nm, "_frame_err_count"}, fe_cnt, m_fe);
        chk({nm, "_overrun_count"}, ov_cnt, m_ov);
        chk({nm, "_accept_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_accept%0d", nm, i), {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Model of one whole frame with ready held steady throughout.
    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) begin
            m_fe++;
        end else if (m_valid && !ready) begin
            m_ov++;
        end else begin
            m_data = b;
            if (ready) exp_q.push_back(b);
            m_valid = !ready;
        end
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #1;
        ready = r;
        if (r && m_valid) begin
            exp_q.push_back(m_data);
            m_valid = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, stop bit; the line is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [7:0] v;
        v = b;
        @(posedge clk); #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(v[i]);
        drive_bit(stop);
    endtask

    task automatic run_frame(input logic [7:0] b, input logic stop, input logic r, input string nm);
        set_ready(r);
        model_frame(b, stop);
        send_frame(b, stop);
        rx = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        check_all(nm);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0, ov0;
        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55, 0, 0};
        vecs[1] = '{8'hA3, 1'b0, 1'b1, 1'b0, 8'h55, 1, 0};
        vecs[2] = '{8'h12, 1'b1, 1'b0, 1'b1, 8'h12, 0, 0};
        vecs[3] = '{8'h34, 1'b1, 1'b0, 1'b1, 8'h12, 0, 1};
        vecs[4] = '{8'hC7, 1'b0, 1'b0, 1'b1, 8'h12, 1, 0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 0, 0};
        vecs[7] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80, 0, 0};

        // Reset state
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, data}, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'h0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'h0);
        chk("rst_overrun", {31'd0, overrun}, 32'h0);

        // Latency and single-cycle valid for 0x55 with ready high
        set_ready(1'b1);
        model_frame(8'h55, 1'b1);
        fork
            send_frame(8'h55, 1'b1);
            begin : meas
                int  n;
                logic seen;
                n = 0;
                seen = 1'b0;
                @(posedge clk);
                while (!seen && n < 300) begin
                    @(posedge clk);
                    n++;
                    #1;
                    if (valid) seen = 1'b1;
                end
                chk("lat_valid_seen", {31'd0, seen}, 32'h1);
                n_cmp++;
                if (n < 153 || n > 156) begin
                    n_bad++;
                    $display("FAIL lat_clocks: got %0d clocks, required 153..156", n);
                end
                @(posedge clk); #1;
                chk("lat_one_cycle", {31'd0, valid}, 32'h0);
            end
        join
        rx = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        check_all("lat");

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            run_frame(vecs[i].b, vecs[i].stop, vecs[i].rdy, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tbl_valid", i), {31'd0, valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d_tbl_data", i), {24'd0, data}, {24'd0, vecs[i].e_data});
            chk($sformatf("vec%0d_tbl_fe", i), fe_cnt - fe0, vecs[i].e_fe);
            chk($sformatf("vec%0d_tbl_ov", i), ov_cnt - ov0, vecs[i].e_ov);
        end

        // Start-bit glitch: 4 clocks low, then high
        @(posedge clk); #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_all("glitch");
        run_frame(8'h3C, 1'b1, 1'b0, "after_glitch");

        // Framing error on 0xA3, then a 200-clock break
        set_ready(1'b1);
        model_frame(8'hA3, 1'b0);
        send_frame(8'hA3, 1'b0);
        repeat (200) @(posedge clk);
        #1;
        check_all("break");
        rx = 1'b1;
        repeat (24) @(posedge clk);
        #1;

        // Back-to-back 0x12, 0x34 with ready low, then ready raised
        set_ready(1'b0);
        model_frame(8'h12, 1'b1);
        send_frame(8'h12, 1'b1);
        model_frame(8'h34, 1'b1);
        send_frame(8'h34, 1'b1);
        rx = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        check_all("ovr");
        @(posedge clk); #1 ready = 1'b1;
        exp_q.push_back(m_data);
        m_valid = 1'b0;
        @(posedge clk); #1;
        chk("ovr_valid_clear", {31'd0, valid}, 32'h0);
        ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_all("ovr_drain");

        // Reset pulsed during the 5th data bit of 0xFF, then 0x81 received
        run_frame(8'h77, 1'b1, 1'b0, "pre_reset");
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (88) @(posedge clk);
                #1 reset = 1'b1;
                repeat (2) @(posedge clk);
                #1 reset = 1'b0;
                m_valid = 1'b0;
                m_data  = 8'h00;
                chk("mid_rst_data", {24'd0, data}, 32'h0);
                chk("mid_rst_valid", {31'd0, valid}, 32'h0);
                chk("mid_rst_fe", {31'd0, frame_err}, 32'h0);
                chk("mid_rst_ov", {31'd0, overrun}, 32'h0);
            end
        join
        rx = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        check_all("mid_rst");
        run_frame(8'h81, 1'b1, 1'b0, "post_rst");

        // Delivery coinciding with acceptance of the previous byte
        fork
            send_frame(8'h6B, 1'b1);
            begin
                repeat (155) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
            end
        join
        exp_q.push_back(m_data);
        m_data  = 8'h6B;
        m_valid = 1'b1;
        rx = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        check_all("coincide");

        // Random frames against the model
        for (int i = 0; i < 12; i++) begin
            logic [7:0] rb;
            logic       rs, rr;
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            rr = 1'($urandom_range(0, 1));
            run_frame(rb, rs, rr, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_rx
